// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg: state encodings and grant constants for the two-master bus arbiter
package mem_bus_arbiter_pkg;
  localparam logic [1:0] ARB_IDLE     = 2'b00;
  localparam logic [1:0] ARB_STROBE   = 2'b01;
  localparam logic [1:0] ARB_WAIT_ACK = 2'b10;
  localparam logic [1:0] ARB_RELEASE  = 2'b11;
  localparam logic [1:0] GNT_NONE     = 2'b00;
  localparam logic [1:0] GNT_M0       = 2'b01;
  localparam logic [1:0] GNT_M1       = 2'b10;
endpackage

// File: rtl/mem_bus_arbiter_rr.sv
// mem_bus_arbiter_rr: two-way winner select, fixed or round-robin, with last-grant history
module mem_bus_arbiter_rr
  import mem_bus_arbiter_pkg::*;
#(
  parameter bit FIXED_PRI = 1'b0
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_req,
  input  logic       i_upd,
  input  logic       i_upd_m1,
  output logic [1:0] o_win
);
  logic r_last_m1;
  // Reset history to M1 so M0 wins the first tie
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_last_m1 <= 1'b1;
    else if (i_upd) r_last_m1 <= i_upd_m1;
  always_comb
    o_win = (&i_req) ? ((FIXED_PRI || r_last_m1) ? GNT_M0 : GNT_M1) :
            i_req[0] ? GNT_M0 : i_req[1] ? GNT_M1 : GNT_NONE;
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one async AS_N/WR_N/ACK_N memory bus between two masters,
// one locked bus cycle at a time, with timeout abort when ACK_N never arrives.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int TO_CYC    = 64,
  parameter bit FIXED_PRI = 1'b0
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_m0_mr,
  input  logic          i_m0_mw,
  input  logic [AW-1:0] i_m0_addr,
  input  logic [DW-1:0] i_m0_dout,
  output logic          o_m0_done,
  input  logic          i_m1_mr,
  input  logic          i_m1_mw,
  input  logic [AW-1:0] i_m1_addr,
  input  logic [DW-1:0] i_m1_dout,
  output logic          o_m1_done,
  output logic [DW-1:0] o_rd_data,
  output logic [AW-1:0] o_bus_addr,
  output logic [DW-1:0] o_bus_dout,
  input  logic [DW-1:0] i_bus_din,
  output logic          o_as_n,
  output logic          o_wr_n,
  input  logic          i_ack_n,
  output logic [1:0]    o_gnt,
  output logic          o_busy,
  output logic          o_timeout,
  output logic [1:0]    o_arb_state
);
  localparam int CW = $clog2(TO_CYC + 1);
  logic [1:0]    r_state, r_gnt, r_done;
  logic [CW-1:0] r_cnt;
  logic          r_as_n, r_wr_n, r_timeout;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_dout, r_rd;
  logic [1:0]    w_req, w_win;
  logic          w_upd;
  assign w_req = {i_m1_mr | i_m1_mw, i_m0_mr | i_m0_mw};
  assign w_upd = (r_state == ARB_RELEASE) && i_ack_n;
  mem_bus_arbiter_rr #(.FIXED_PRI(FIXED_PRI)) u_rr (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_req    (w_req),
    .i_upd    (w_upd),
    .i_upd_m1 (r_gnt[1]),
    .o_win    (w_win)
  );
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_state   <= ARB_IDLE;
      r_gnt     <= GNT_NONE;
      r_done    <= GNT_NONE;
      r_cnt     <= '0;
      r_as_n    <= 1'b1;
      r_wr_n    <= 1'b1;
      r_timeout <= 1'b0;
      r_addr    <= '0;
      r_dout    <= '0;
      r_rd      <= '0;
    end else begin
      r_done    <= GNT_NONE;
      r_timeout <= 1'b0;
      case (r_state)
        ARB_IDLE: if (|w_req) begin
          r_state <= ARB_STROBE;
          r_gnt   <= w_win;
          r_as_n  <= 1'b0;
          r_addr  <= w_win[1] ? i_m1_addr : i_m0_addr;
          r_dout  <= w_win[1] ? i_m1_dout : i_m0_dout;
          r_wr_n  <= w_win[1] ? ~i_m1_mw : ~i_m0_mw;
        end
        ARB_STROBE: begin
          r_cnt   <= '0;
          r_state <= ARB_WAIT_ACK;
        end
        ARB_WAIT_ACK: if (!i_ack_n || r_cnt == CW'(TO_CYC - 1)) begin
          r_state   <= ARB_RELEASE;
          r_as_n    <= 1'b1;
          r_wr_n    <= 1'b1;
          r_done    <= r_gnt;
          r_timeout <= i_ack_n;
          if (!i_ack_n) r_rd <= i_bus_din;
        end else r_cnt <= r_cnt + CW'(1);
        default: if (i_ack_n) begin
          r_state <= ARB_IDLE;
          r_gnt   <= GNT_NONE;
        end
      endcase
    end
  assign o_m0_done   = r_done[0];
  assign o_m1_done   = r_done[1];
  assign o_rd_data   = r_rd;
  assign o_bus_addr  = r_addr;
  assign o_bus_dout  = r_dout;
  assign o_as_n      = r_as_n;
  assign o_wr_n      = r_wr_n;
  assign o_gnt       = r_gnt;
  assign o_busy      = r_state != ARB_IDLE;
  assign o_timeout   = r_timeout;
  assign o_arb_state = r_state;
endmodule
